// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_8
// Purpose  : Eight-way round-robin arbiter with registered one-hot grant and
//            encoded owner index. Define ARB_TIMEOUT_EN to build the hold
//            counter and forced rotation after HOLD_MAX grant cycles.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
        $error("rr_arbiter_8: HOLD_MAX must be in 1..255");
    end

    logic [7:0] r_grant;
    logic [2:0] r_grant_id;
    logic       r_grant_valid;
    logic [2:0] r_ptr;

    logic       w_release;
    logic       w_force;
    logic       w_found;
    logic [2:0] w_search_ptr;
    logic [7:0] w_rot;
    logic [2:0] w_off;
    logic [2:0] w_winner;

    assign w_release = r_grant_valid && !req[r_grant_id];

    // On a release or forced rotation the search already starts past the owner.
    assign w_search_ptr = (w_release || w_force) ? (r_grant_id + 3'd1) : r_ptr;

    always_comb begin
        w_rot = '0;
        for (int k = 0; k < 8; k++) begin
            w_rot[k] = req[3'(w_search_ptr + 3'(k))];
        end
    end

    always_comb begin
        w_off = '0;
        for (int k = 7; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 3'(k);
            end
        end
    end

    assign w_found  = |req;
    assign w_winner = w_search_ptr + w_off;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_ptr         <= '0;
        end else if (!en) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
        end else if (!r_grant_valid) begin
            if (w_found) begin
                r_grant_valid <= 1'b1;
                r_grant_id    <= w_winner;
                r_grant       <= 8'b1 << w_winner;
            end
        end else if (w_release || w_force) begin
            r_ptr <= r_grant_id + 3'd1;
            if (w_found) begin
                r_grant_id <= w_winner;
                r_grant    <= 8'b1 << w_winner;
            end else begin
                r_grant_valid <= 1'b0;
                r_grant       <= '0;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold_cnt;
    logic       r_timeout;

    // Rotation is only forced when someone else is actually waiting.
    assign w_force = en && r_grant_valid && req[r_grant_id]
                     && (r_hold_cnt == 8'(HOLD_MAX))
                     && ((req & ~r_grant) != 8'h00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (!en) begin
                r_hold_cnt <= '0;
            end else if (!r_grant_valid || w_release || w_force) begin
                r_hold_cnt <= w_found ? 8'd1 : 8'd0;
                r_timeout  <= w_force;
            end else if (r_hold_cnt != 8'hFF) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_8
// Purpose  : Scoreboard bench for rr_arbiter_8: directed scenarios plus random
//            traffic checked against a behavioural round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_8;

    localparam int HOLD_MAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    rr_arbiter_8 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] id;
        logic       valid;
        logic       tout;
        logic       chk_id;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model state: owner, rotation start and grant age.
    int m_valid = 0;
    int m_id    = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_tout  = 0;

    function automatic int pick(int start, logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(logic rn, logic e, logic [7:0] r);
        int to_hit;
        m_tout = 0;
        to_hit = 0;
        if (!rn) begin
            m_valid = 0; m_id = 0; m_ptr = 0; m_hold = 0;
        end else if (!e) begin
            m_valid = 0; m_hold = 0;
        end else if (m_valid == 0) begin
            if (r != 8'h00) begin
                m_valid = 1; m_id = pick(m_ptr, r); m_hold = 1;
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (r[m_id] && m_hold == HOLD_MAX && (r & ~(8'd1 << m_id)) != 8'h00)
                to_hit = 1;
`endif
            if (!r[m_id] || to_hit != 0) begin
                m_ptr = (m_id + 1) % 8;
                if (r != 8'h00) begin
                    m_id = pick(m_ptr, r); m_hold = 1; m_tout = to_hit;
                end else begin
                    m_valid = 0;
                end
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end
    endtask

    task automatic drive(logic rn, logic e, logic [7:0] r);
        exp_t x;
        @(negedge clk);
        rst_n = rn;
        en    = e;
        req   = r;
        model_step(rn, e, r);
        x.valid  = (m_valid != 0);
        x.id     = 3'(m_id);
        x.grant  = (m_valid != 0) ? (8'd1 << m_id) : 8'h00;
        x.tout   = (m_tout != 0);
        x.chk_id = (m_valid != 0) || !rn;
        q.push_back(x);
    endtask

    // Monitor: one expected record per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (grant !== e.grant || grant_valid !== e.valid || timeout !== e.tout
                    || (e.chk_id && grant_id !== e.id)) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got grant=%h id=%0d valid=%b timeout=%b, want grant=%h id=%0d valid=%b timeout=%b",
                             $time, grant, grant_id, grant_valid, timeout, e.grant, e.id, e.valid, e.tout);
                end
                n_tests++;
                if (grant !== (grant_valid ? (8'd1 << grant_id) : 8'h00)) begin
                    n_fail++;
                    $display("FAIL onehot t=%0t: got grant=%h, want decode of id=%0d valid=%b",
                             $time, grant, grant_id, grant_valid);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        int roll;

        // Reset, then fairness sweep with every owner dropping its request.
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 8'hFF);
            drive(1'b1, 1'b1, 8'hFF & ~(8'd1 << m_id));
        end

        // Wrap priority: owner 6 releases, requester 0 next.
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h40);
        drive(1'b1, 1'b1, 8'h41);
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b1, 8'h01);

        // Enable gating around owner 3.
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h08);
        drive(1'b1, 1'b1, 8'h08);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h08);
        drive(1'b1, 1'b1, 8'h08);
        drive(1'b1, 1'b1, 8'h08);

        // Reset mid-grant.
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h20);
        drive(1'b1, 1'b1, 8'h20);
        drive(1'b0, 1'b1, 8'h20);
        drive(1'b1, 1'b1, 8'h22);
        drive(1'b1, 1'b1, 8'h22);

`ifdef ARB_TIMEOUT_EN
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 8'h03);
`endif

        // Lone holder never rotates.
        drive(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 8'h10);

        // Random traffic.
        r = 8'hA5;
        for (int i = 0; i < 600; i++) begin
            roll = $urandom_range(0, 99);
            if (roll < 25)
                r = r ^ (8'd1 << $urandom_range(0, 7));
            else if (roll < 30)
                r = 8'($urandom);
            else if (roll < 40 && m_valid != 0)
                r = r & ~(8'd1 << m_id);
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 19) != 0, r);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending records, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
